// File: rtl/apb_master.sv
// APB requester: turns single user commands into APB SETUP/ACCESS transfers.
// A transfer completes when the completer raises pready. If pready stays low
// for TIMEOUT ACCESS cycles, the transfer is aborted with an error response.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    // Counter value at which one more low-pready edge means TIMEOUT waits.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // Commands are only taken while no transfer is in flight.
    assign cmd_ready = (state == IDLE);

    // Transfer sequencing, APB bus outputs and response registers.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        // pready wins even on the edge the timeout would fire.
                        state       <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        wait_cnt    <= wait_cnt + 8'd1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, hand-written
// reset/back-to-back sequences and randomized transfers against a model.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;   // what the completer returns when ready
        int          nwait;   // low-pready ACCESS cycles before ready
        bit          slverr;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_lat; // negedges from accept edge to rsp_valid
        int          exp_pen; // cycles with penable high
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: response and timing follow directly from the wait count.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.nwait >= TO) begin
            r.exp_rdata = 32'h0;
            r.exp_err   = 1'b1;
            r.exp_to    = 1'b1;
            r.exp_pen   = TO;
            r.exp_lat   = TO + 2;
        end else begin
            r.exp_rdata = v.w ? 32'h0 : v.rdata;
            r.exp_err   = v.slverr;
            r.exp_to    = 1'b0;
            r.exp_pen   = v.nwait + 1;
            r.exp_lat   = v.nwait + 3;
        end
        return r;
    endfunction

    // Garbage on the completer inputs; must be ignored outside ready ACCESS.
    task automatic noise();
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
    endtask

    // Called right after a negedge with the DUT idle; returns at the
    // negedge on which rsp_valid is seen (DUT idle again).
    task automatic run_xfer(input vec_t v, input string tag);
        int lat;
        int pen;
        bit done;
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.w;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        noise();
        @(negedge pclk);
        lat = 1;
        pen = 0;
        done = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        chk({tag, ".setup_psel"}, 32'(psel), 32'd1);
        chk({tag, ".setup_penable"}, 32'(penable), 32'd0);
        chk({tag, ".setup_pwrite"}, 32'(pwrite), 32'(v.w));
        chk({tag, ".setup_paddr"}, paddr, v.addr);
        chk({tag, ".setup_pwdata"}, pwdata, v.wdata);
        chk({tag, ".setup_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, ".setup_rsp_valid"}, 32'(rsp_valid), 32'd0);
        noise();
        while (!done) begin
            @(negedge pclk);
            lat++;
            if (rsp_valid) begin
                done = 1'b1;
            end else if (lat > TO + 6) begin
                chk({tag, ".rsp_within_bound"}, 32'(rsp_valid), 32'd1);
                done = 1'b1;
            end else begin
                chk({tag, ".acc_psel"}, 32'(psel), 32'd1);
                chk({tag, ".acc_penable"}, 32'(penable), 32'd1);
                chk({tag, ".acc_paddr"}, paddr, v.addr);
                chk({tag, ".acc_pwdata"}, pwdata, v.wdata);
                pen++;
                if (pen - 1 == v.nwait) begin
                    pready  = 1'b1;
                    prdata  = v.rdata;
                    pslverr = v.slverr;
                end else begin
                    pready  = 1'b0;
                    prdata  = $urandom;
                    pslverr = 1'($urandom);
                end
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, ".penable_cycles"}, 32'(pen), 32'(v.exp_pen));
        chk({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
        chk({tag, ".done_psel"}, 32'(psel), 32'd0);
        chk({tag, ".done_penable"}, 32'(penable), 32'd0);
        chk({tag, ".hold_paddr"}, paddr, v.addr);
        chk({tag, ".hold_pwrite"}, 32'(pwrite), 32'(v.w));
        noise();
    endtask

    // Protocol rule checked on every cycle once out of reset.
    always @(negedge pclk) begin
        if (mon_on) begin
            checks++;
            if (penable && !psel) begin
                errors++;
                $display("FAIL penable_without_psel actual=1 required=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 32'h4,  32'hDEADBEEF, 32'h0,        0,  1'b0, 32'h0,        1'b0, 1'b0, 3,  1};
        tbl[1] = '{1'b0, 32'h8,  32'h0,        32'h12345678, 2,  1'b0, 32'h12345678, 1'b0, 1'b0, 5,  3};
        tbl[2] = '{1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 0,  1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 3,  1};
        tbl[3] = '{1'b0, 32'h80, 32'h0,        32'h55555555, 16, 1'b0, 32'h0,        1'b1, 1'b1, 18, 16};
        tbl[4] = '{1'b0, 32'h84, 32'h0,        32'hA5A5A5A5, 15, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 18, 16};
        tbl[5] = '{1'b1, 32'hC,  32'h01020304, 32'h77777777, 3,  1'b1, 32'h0,        1'b1, 1'b0, 6,  4};
        tbl[6] = '{1'b1, 32'h10, 32'h0BADF00D, 32'h0,        20, 1'b0, 32'h0,        1'b1, 1'b1, 18, 16};

        preset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        prdata = '0;
        pready = 1'b0;
        pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst.psel", 32'(psel), 32'd0);
        chk("rst.penable", 32'(penable), 32'd0);
        chk("rst.pwrite", 32'(pwrite), 32'd0);
        chk("rst.paddr", paddr, 32'h0);
        chk("rst.pwdata", pwdata, 32'h0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        preset_n = 1'b1;
        mon_on = 1'b1;
        @(negedge pclk);

        // Directed table; consecutive entries also start on the rsp cycle.
        for (int i = 0; i < 7; i++) begin
            run_xfer(tbl[i], $sformatf("vec%0d", i));
        end
        @(negedge pclk);
        chk("pulse.rsp_valid_low", 32'(rsp_valid), 32'd0);

        // Reset during SETUP (s=1) and during ACCESS (s=2) of a write.
        for (int s = 1; s <= 2; s++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h100;
            cmd_wdata = 32'h11112222;
            pready = 1'b0;
            repeat (s) begin
                @(negedge pclk);
                cmd_valid = 1'b0;
            end
            chk($sformatf("rstmid%0d.psel_before", s), 32'(psel), 32'd1);
            chk($sformatf("rstmid%0d.penable_before", s), 32'(penable), 32'(s - 1));
            preset_n = 1'b0;
            @(negedge pclk);
            chk($sformatf("rstmid%0d.psel", s), 32'(psel), 32'd0);
            chk($sformatf("rstmid%0d.penable", s), 32'(penable), 32'd0);
            chk($sformatf("rstmid%0d.rsp_valid", s), 32'(rsp_valid), 32'd0);
            chk($sformatf("rstmid%0d.paddr", s), paddr, 32'h0);
            preset_n = 1'b1;
            pready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge pclk);
                chk($sformatf("rstmid%0d.cmd_ready_%0d", s, k), 32'(cmd_ready), 32'd1);
                chk($sformatf("rstmid%0d.no_rsp_%0d", s, k), 32'(rsp_valid), 32'd0);
            end
        end

        // Two writes with cmd_valid held; second taken on first's rsp cycle.
        pready = 1'b1;
        pslverr = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h200;
        cmd_wdata = 32'hAAAA0001;
        @(negedge pclk);
        chk("b2b.a_paddr", paddr, 32'h200);
        cmd_addr  = 32'h204;
        cmd_wdata = 32'hBBBB0002;
        @(negedge pclk);
        chk("b2b.a_penable", 32'(penable), 32'd1);
        @(negedge pclk);
        chk("b2b.a_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b.a_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("b2b.b_psel", 32'(psel), 32'd1);
        chk("b2b.b_paddr", paddr, 32'h204);
        chk("b2b.b_pwdata", pwdata, 32'hBBBB0002);
        chk("b2b.b_rsp_valid_low", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        chk("b2b.b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b.b_rsp_err", 32'(rsp_err), 32'd0);

        // Randomized transfers against the model.
        for (int n = 0; n < 30; n++) begin
            rv.w      = 1'($urandom);
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.rdata  = $urandom;
            rv.slverr = 1'($urandom);
            rv.nwait  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO + 3))
                                                    : int'($urandom_range(0, 3));
            rv = model(rv);
            run_xfer(rv, $sformatf("rnd%0d", n));
        end
        @(negedge pclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles with pready low before abort (range 1..255).
REQ-004 pclk  input  1  sole clock, all logic on rising edge.
REQ-005 preset_n  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid  input  1  user requests a transfer.
REQ-007 cmd_ready  output  1  block accepts a command this cycle.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse, transfer finished.
REQ-012 rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  slave error or timeout, valid with rsp_valid.
REQ-014 rsp_timeout  output  1  abort due to timeout, valid with rsp_valid.
REQ-015 psel, penable, pwrite  output  1 each  APB requester controls.
REQ-016 paddr  output  ADDR_W;  pwdata  output  DATA_W  APB address/write data.
REQ-017 prdata  input  DATA_W;  pready, pslverr  input  1 each  APB completer response.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs except cmd_ready SHALL be registered.
REQ-019 cmd_ready SHALL equal (state == IDLE), combinational from state only; command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-020 On acceptance: capture cmd_write/addr/wdata into pwrite/paddr/pwdata, go to SETUP; next cycle psel=1, penable=0.
REQ-021 SETUP SHALL last exactly one cycle, then ACCESS: psel=1, penable=1; paddr, pwrite, pwdata SHALL stay stable through SETUP and ACCESS.
REQ-022 In ACCESS, pready=1 at an edge SHALL complete: psel=0, penable=0, state IDLE, rsp_valid=1 for exactly the following cycle.
REQ-023 On completion rsp_err SHALL equal sampled pslverr, rsp_timeout=0; for reads rsp_rdata SHALL equal sampled prdata, for writes rsp_rdata SHALL be 0.
REQ-024 prdata and pslverr SHALL be ignored whenever pready=0 or state is not ACCESS.
REQ-025 Wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
REQ-026 When the counter reaches TIMEOUT with pready still 0: abort to IDLE, psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 pready=1 on the same edge the counter reaches TIMEOUT SHALL count as normal completion, not timeout.
REQ-028 Minimum transfer: accept edge, SETUP, one ACCESS cycle; rsp_valid asserts 3 cycles after the accept edge.
REQ-029 Back-to-back: a command may be accepted in the same IDLE cycle that rsp_valid is high; no APB bus idle cycle beyond that IDLE cycle is required.
REQ-030 When not selected, pwrite/paddr/pwdata SHALL hold last values; penable SHALL never be 1 while psel=0.

Reset
REQ-031 While preset_n=0 at a rising edge: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter 0.
REQ-032 Reset asserted mid-SETUP or mid-ACCESS SHALL abandon the transfer with no rsp_valid for it; cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 Write 0x4 <- 0xDEADBEEF, pready=1 first ACCESS cycle -> SETUP then ACCESS, paddr=0x4, pwdata=0xDEADBEEF, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-034 Read 0x8, slave returns 0x12345678 after 2 wait cycles -> penable high 3 cycles, rsp_rdata=0x12345678, rsp_err=0.
REQ-035 Read 0x40 with pslverr=1, pready=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata sampled.
REQ-036 pready held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0 next cycle.
REQ-037 preset_n=0 during ACCESS of a write -> psel=penable=0 next edge, no rsp_valid, cmd_ready=1 after release.
REQ-038 Two back-to-back writes with cmd_valid held -> second accepted on rsp_valid cycle of first, penable never high with psel low, no lost command.
